s_cpu_muldiv: RTL
=================

S_CPU_MULDIV -- requirements
Module: s_cpu_muldiv

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start_mul, input, 1, request MUL YA (Y*A).
REQ-004 SHALL have port start_div, input, 1, request DIV YA,X.
REQ-005 SHALL have port a_in, input, 8, register A operand.
REQ-006 SHALL have port y_in, input, 8, register Y operand.
REQ-007 SHALL have port x_in, input, 8, register X divisor.
REQ-008 SHALL have port busy, output, 1, operation in progress.
REQ-009 SHALL have port done, output, 1, one-cycle result-valid pulse.
REQ-010 SHALL have port a_out, output, 8, result A.
REQ-011 SHALL have port y_out, output, 8, result Y.
REQ-012 SHALL have port flg_nvhz, output, 4, result flags {N,V,H,Z}.

Function
REQ-013 SHALL use a three-state FSM: IDLE, MUL, DIV.
REQ-014 SHALL use a 4-bit step counter.
REQ-015 SHALL sample operands only in IDLE when a start is seen.
REQ-016 SHALL give start_mul priority when start_mul and start_div are both high.
REQ-017 SHALL ignore start_* while busy=1.
REQ-018 SHALL hold busy=1 from the cycle after the start edge until and including the done cycle; done SHALL be high for exactly one cycle, coincident with updated outputs.
REQ-019 MUL: SHALL iterate shift-add, one multiplier bit per cycle for 8 cycles; done SHALL assert 8 cycles after the start edge.
REQ-020 MUL result: {y_out,a_out} = y_in*a_in (16-bit, unsigned); N = y_out[7]; Z = (y_out==0); V and H SHALL be unchanged from their previous output values.
REQ-021 DIV: SHALL use a 17-bit work register w = {1'b0,y_in,a_in} and subtractor s = {x_in,9'h0}.
REQ-022 Each DIV iteration, 9 total, one per cycle: w = rotate-left-17(w); if w >= s then w[0] ^= 1; if w[0] then w = (w - s) mod 2^17.
REQ-023 One finalize cycle SHALL follow the iterations; done SHALL assert 10 cycles after the start edge.
REQ-024 DIV result: a_out = w[7:0]; y_out = w[16:9]; V = w[8]; H = (y_in[3:0] >= x_in[3:0]) on the sampled operands; N = a_out[7]; Z = (a_out==0).
REQ-025 Divide-by-zero and quotient overflow SHALL need no special-casing; they SHALL follow REQ-022 exactly.
REQ-026 Outputs SHALL hold their last result until the next done.
REQ-027 Operand input changes during busy SHALL have no effect.

Reset
REQ-028 Reset SHALL force state IDLE, counter 0, busy 0, done 0, a_out 00, y_out 00, flg_nvhz 0000.
REQ-029 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-030 A start_* high in the same cycle as reset SHALL be ignored.

Configuration
REQ-031 With macro S_CPU_MULDIV_FAST_EN defined: SHALL compute MUL and DIV results (identical values and flags) in a single cycle; done SHALL assert 1 cycle after the start edge; busy SHALL be high only in the done cycle.
REQ-032 Without S_CPU_MULDIV_FAST_EN: SHALL use the iterative timing of REQ-019 and REQ-023.

Verification
REQ-033 MUL: A=34h, Y=12h -> done 8 cycles later; Y=03h, A=A8h; N=0, Z=0.
REQ-034 DIV: YA=0123h, X=10h -> done 10 cycles later; A=12h, Y=03h; V=0, H=1, N=0, Z=0.
REQ-035 DIV by zero: YA=1234h, X=00h -> A=EDh, Y=34h; V=1, H=1, N=1, Z=0.
REQ-036 MUL zero: A=00h, Y=55h -> YA=0000h, Z=1, N=0; V/H keep the values from the previous DIV.
REQ-037 start_mul=start_div=1 -> MUL executes. A second start at cycle 3 -> ignored, exactly one done pulse.
REQ-038 reset at cycle 5 of a DIV -> no done pulse, all outputs 0. A new MUL immediately after -> correct result.

Source files
------------

// File: rtl/s_cpu_muldiv.sv
// 8-bit MUL YA / DIV YA,X unit: iterative shift-add / restoring-style divide.
// Define S_CPU_MULDIV_FAST_EN for single-cycle results with identical values and flags.
module s_cpu_muldiv (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_mul,
   input  logic       start_div,
   input  logic [7:0] a_in,
   input  logic [7:0] y_in,
   input  logic [7:0] x_in,
   output logic       busy,
   output logic       done,
   output logic [7:0] a_out,
   output logic [7:0] y_out,
   output logic [3:0] flg_nvhz
);

   typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [16:0] w_q, w_d;
   logic [7:0]  m_q, m_d;      // multiplicand (MUL) or divisor (DIV)
   logic        h_q, h_d;
   logic        done_q, done_d;
   logic [7:0]  a_q, a_d, y_q, y_d;
   logic [3:0]  flg_q, flg_d;
   logic [16:0] wf;
   logic        last;

   function automatic logic [16:0] mul_step(input logic [16:0] w, input logic [7:0] y);
      logic [8:0] sum;
      sum = {1'b0, w[15:8]} + (w[0] ? {1'b0, y} : 9'h000);
      return {1'b0, sum, w[7:1]};
   endfunction

   // Rotate, set quotient bit when w >= s, then subtract if the bit ended up set.
   function automatic logic [16:0] div_step(input logic [16:0] w, input logic [7:0] x);
      logic [16:0] r;
      logic [16:0] s;
      s = {x, 9'h000};
      r = {w[15:0], w[16]};
      if (r >= s) r[0] = ~r[0];
      if (r[0]) r = r - s;
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      w_d     = w_q;
      m_d     = m_q;
      h_d     = h_q;
      done_d  = 1'b0;
      a_d     = a_q;
      y_d     = y_q;
      flg_d   = flg_q;
      wf      = w_q;
      last    = 1'b0;
      case (state_q)
         StIdle: begin
            // The done cycle still counts as busy, so starts are refused there too.
            if (!done_q && (start_mul || start_div)) begin
               cnt_d   = 4'd0;
               h_d     = (y_in[3:0] >= x_in[3:0]);
               if (start_mul) begin
                  state_d = StMul;
                  m_d     = y_in;
                  w_d     = {9'h000, a_in};
               end else begin
                  state_d = StDiv;
                  m_d     = x_in;
                  w_d     = {1'b0, y_in, a_in};
               end
            end
         end
         StMul: begin
`ifdef S_CPU_MULDIV_FAST_EN
            wf   = 17'(m_q) * 17'(w_q[7:0]);
            last = 1'b1;
`else
            wf    = mul_step(w_q, m_q);
            cnt_d = cnt_q + 4'd1;
            last  = (cnt_q == 4'd7);
`endif
            w_d = wf;
            if (last) begin
               state_d = StIdle;
               done_d  = 1'b1;
               y_d     = wf[15:8];
               a_d     = wf[7:0];
               flg_d   = {wf[15], flg_q[2:1], (wf[15:8] == 8'h00)};
            end
         end
         StDiv: begin
`ifdef S_CPU_MULDIV_FAST_EN
            for (int i = 0; i < 9; i++) wf = div_step(wf, m_q);
            last = 1'b1;
`else
            last = (cnt_q == 4'd9);
            if (!last) begin
               wf    = div_step(w_q, m_q);
               cnt_d = cnt_q + 4'd1;
            end
`endif
            w_d = wf;
            if (last) begin
               state_d = StIdle;
               done_d  = 1'b1;
               a_d     = wf[7:0];
               y_d     = wf[16:9];
               flg_d   = {wf[7], wf[8], h_q, (wf[7:0] == 8'h00)};
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         w_q     <= 17'h0;
         m_q     <= 8'h00;
         h_q     <= 1'b0;
         done_q  <= 1'b0;
         a_q     <= 8'h00;
         y_q     <= 8'h00;
         flg_q   <= 4'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         w_q     <= w_d;
         m_q     <= m_d;
         h_q     <= h_d;
         done_q  <= done_d;
         a_q     <= a_d;
         y_q     <= y_d;
         flg_q   <= flg_d;
      end
   end

`ifdef S_CPU_MULDIV_FAST_EN
   assign busy = done_q;
`else
   assign busy = (state_q != StIdle) || done_q;
`endif
   assign done     = done_q;
   assign a_out    = a_q;
   assign y_out    = y_q;
   assign flg_nvhz = flg_q;

endmodule
